// File: rtl/count_sched.sv
// count_sched: round-robin arbiter that lends one shared up-counter to one
// requester at a time. The winner's counter is cleared and then enabled
// until it reaches the winner's target. The window can also end early if
// the winner drops its request. Each window ends with a one-cycle done
// pulse that carries the winner's id.
module count_sched #(
    parameter int NREQ = 4,
    parameter int CW   = 8,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*CW-1:0] tgt,
    input  logic [CW-1:0]     count,
    output logic              cnt_clr,
    output logic              cnt_en,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              done,
    output logic [IDW-1:0]    done_id,
    output logic              abort
);

    // One extra bit so that ptr + k can be reduced modulo NREQ without overflow.
    localparam int SW = IDW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [IDW-1:0]    ptr_reg;
    logic [IDW-1:0]    id_reg;
    logic [CW-1:0]     tgt_reg;
    logic [NREQ-1:0]   gnt_reg;
    logic              done_reg;
    logic [IDW-1:0]    done_id_reg;
    logic              abort_reg;

    logic              pick_found;
    logic [IDW-1:0]    pick_id;
    logic [SW-1:0]     pick_sum;
    logic              abort_next;

    // Unflattened view of the target bus, one entry per requester.
    logic [CW-1:0]     tgt_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_tgt
        assign tgt_arr[gi] = tgt[gi*CW +: CW];
    end

    // Round-robin pick: first requester at or after ptr+1, wrapping modulo NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        pick_sum   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            pick_sum = {1'b0, ptr_reg} + SW'(k);
            if (pick_sum >= SW'(NREQ)) begin
                pick_sum = pick_sum - SW'(NREQ);
            end
            if (!pick_found && req[pick_sum[IDW-1:0]]) begin
                pick_found = 1'b1;
                pick_id    = pick_sum[IDW-1:0];
            end
        end
    end

    // Next-state logic plus the combinational counter enable used during RUN.
    always_comb begin
        state_next = state_reg;
        abort_next = 1'b0;
        cnt_en     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                state_next = RUN;
            end
            RUN: begin
                cnt_en = (count != tgt_reg) && req[id_reg];
                // Reaching the target wins over a simultaneous request drop.
                if (count == tgt_reg) begin
                    state_next = DONE;
                    abort_next = 1'b0;
                end else if (!req[id_reg]) begin
                    state_next = DONE;
                    abort_next = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register, grant/target latches and the registered completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            ptr_reg     <= IDW'(NREQ - 1);
            id_reg      <= '0;
            tgt_reg     <= '0;
            gnt_reg     <= '0;
            done_reg    <= 1'b0;
            done_id_reg <= '0;
            abort_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            abort_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // The target is captured only here; later changes on tgt are ignored.
                    if (pick_found) begin
                        id_reg  <= pick_id;
                        tgt_reg <= tgt_arr[pick_id];
                        gnt_reg <= {{(NREQ-1){1'b0}}, 1'b1} << pick_id;
                    end
                end
                RUN: begin
                    if (state_next == DONE) begin
                        done_reg    <= 1'b1;
                        done_id_reg <= id_reg;
                        abort_reg   <= abort_next;
                    end
                end
                DONE: begin
                    ptr_reg <= id_reg;
                    gnt_reg <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign cnt_clr = (state_reg == CLEAR);
    assign busy    = (state_reg != IDLE);
    assign gnt     = gnt_reg;
    assign done    = done_reg;
    assign done_id = done_id_reg;
    assign abort   = abort_reg;

endmodule
